// File: rtl/wb_arbiter.sv
// wb_arbiter: regfile write-port arbiter between a single-cycle ALU and a
// multi-cycle MDU. MDU results are held in a 2-entry in-order FIFO. The ALU
// normally wins the write port, but a FIFO head that has waited MaxWait
// cycles raises stall_o and takes priority on the following edge.
module wb_arbiter #(
  parameter int Size    = 64,
  parameter int MaxWait = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd_addr,
  input  logic [Size-1:0] alu_rd_i,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd_addr,
  input  logic [Size-1:0] mdu_rd_i,
  output logic            load,
  output logic [4:0]      rd_addr,
  output logic [Size-1:0] rd_i,
  output logic [31:0]     pending_o,
  output logic            stall_o
);

  localparam int AgeW = (MaxWait < 2) ? 1 : $clog2(MaxWait + 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_FIFO,
    SEL_ALU
  } sel_e;

  // Entry 0 is always the head; entry 1 is only meaningful when count == 2.
  logic [4:0]      fifo_addr [2];
  logic [Size-1:0] fifo_data [2];
  logic [1:0]      count;
  logic [AgeW-1:0] age;

  sel_e sel;
  logic push;
  logic pop;
  logic alu_ok;

  // Handshake, stall and write-port source selection.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mdu_ready = !reset && (count < 2'd2);
    stall_o   = (count != 2'd0) && (age == AgeW'(MaxWait));
    // x0 results are handshaked but never enqueued.
    push      = mdu_valid && mdu_ready && (mdu_rd_addr != 5'd0);
    alu_ok    = alu_valid && (alu_rd_addr != 5'd0);
    sel       = SEL_NONE;
    if (stall_o) begin
      sel = SEL_FIFO;            // ALU data during a stall is ignored
    end else if (alu_ok) begin
      sel = SEL_ALU;
    end else if (count != 2'd0) begin
      sel = SEL_FIFO;
    end
    pop = (sel == SEL_FIFO);
  end

  // One-hot map of destinations still waiting in the FIFO.
  always_comb begin
    pending_o = '0;
    if (count != 2'd0) pending_o[fifo_addr[0]] = 1'b1;
    if (count == 2'd2) pending_o[fifo_addr[1]] = 1'b1;
    pending_o[0] = 1'b0;
  end

  // FIFO occupancy, head age and the registered regfile write port.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 2'd0;
      age     <= '0;
      load    <= 1'b0;
      rd_addr <= 5'd0;
      rd_i    <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // A fresh head (after a pop or into an empty FIFO) starts at age 0.
      if (pop || (count == 2'd0)) begin
        age <= '0;
      end else if (age != AgeW'(MaxWait)) begin
        age <= age + 1'b1;
      end

      case (sel)
        SEL_ALU: begin
          load    <= 1'b1;
          rd_addr <= alu_rd_addr;
          rd_i    <= alu_rd_i;
        end
        SEL_FIFO: begin
          load    <= 1'b1;
          rd_addr <= fifo_addr[0];
          rd_i    <= fifo_data[0];
        end
        default: load <= 1'b0;
      endcase
    end
  end

  // FIFO payload storage: shift toward the head on pop, write at the tail on push.
  // NOTE: payload is not reset; validity comes solely from count, which is reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_addr[0] <= fifo_addr[1];
      fifo_data[0] <= fifo_data[1];
    end
    if (push) begin
      if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
        fifo_addr[0] <= mdu_rd_addr;
        fifo_data[0] <= mdu_rd_i;
      end else begin
        fifo_addr[1] <= mdu_rd_addr;
        fifo_data[1] <= mdu_rd_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

  localparam int SIZE     = 64;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd_addr = '0;
  logic [SIZE-1:0] alu_rd_i = '0;
  logic            mdu_valid = 1'b0;
  logic            mdu_ready;
  logic [4:0]      mdu_rd_addr = '0;
  logic [SIZE-1:0] mdu_rd_i = '0;
  logic            load;
  logic [4:0]      rd_addr;
  logic [SIZE-1:0] rd_i;
  logic [31:0]     pending_o;
  logic            stall_o;

  int checks = 0;
  int passed = 0;

  wb_arbiter #(.Size(SIZE), .MaxWait(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_rd_i(alu_rd_i),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rd_addr(mdu_rd_addr), .mdu_rd_i(mdu_rd_i),
    .load(load), .rd_addr(rd_addr), .rd_i(rd_i),
    .pending_o(pending_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]      addr;
    logic [SIZE-1:0] data;
  } entry_t;

  entry_t          q[$];
  int              m_age = 0;
  logic            m_load = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [SIZE-1:0] m_data = '0;

  function automatic logic m_ready();
    return !reset && (q.size() < 2);
  endfunction

  function automatic logic m_stall();
    return (q.size() > 0) && (m_age == MAX_WAIT);
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].addr] = 1'b1;
    return p;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_age  = 0;
    m_load = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  // Advance one rising edge, update the model from the inputs seen at that edge.
  task automatic tick();
    int     n;
    logic   stall;
    logic   alu_ok;
    logic   popped;
    entry_t e;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      n      = q.size();
      stall  = (n > 0) && (m_age == MAX_WAIT);
      alu_ok = alu_valid && (alu_rd_addr != 0);
      popped = 1'b0;
      if (stall || (!alu_ok && n > 0)) begin
        e = q.pop_front();
        m_load = 1'b1; m_addr = e.addr; m_data = e.data;
        popped = 1'b1;
      end else if (alu_ok) begin
        m_load = 1'b1; m_addr = alu_rd_addr; m_data = alu_rd_i;
      end else begin
        m_load = 1'b0;
      end
      if (mdu_valid && n < 2 && mdu_rd_addr != 0) begin
        e.addr = mdu_rd_addr;
        e.data = mdu_rd_i;
        q.push_back(e);
      end
      if (popped || n == 0) m_age = 0;
      else if (m_age < MAX_WAIT) m_age++;
    end
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [SIZE-1:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [SIZE-1:0] md);
    alu_valid = av; alu_rd_addr = aa; alu_rd_i = ad;
    mdu_valid = mv; mdu_rd_addr = ma; mdu_rd_i = md;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    checks++; if (load !== 1'b0) $display("FAIL reset_load: got %b want 0", load); else passed++;
    checks++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else passed++;
    checks++; if (rd_i !== '0) $display("FAIL reset_rd_i: got %h want 0", rd_i); else passed++;
    checks++; if (pending_o !== 32'd0) $display("FAIL reset_pending: got %h want 0", pending_o); else passed++;
    checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
    checks++; if (mdu_ready !== 1'b0) $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready); else passed++;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (mdu_ready !== 1'b1) $display("FAIL release_mdu_ready: got %b want 1", mdu_ready); else passed++;
  endtask

  task automatic test_alu_only();
    drive(1'b1, 5'd5, 64'hAAAA, 1'b0, 5'd0, '0);
    tick();
    checks++; if (load !== 1'b1) $display("FAIL alu_load: got %b want 1", load); else passed++;
    checks++; if (rd_addr !== 5'd5) $display("FAIL alu_rd_addr: got %0d want 5", rd_addr); else passed++;
    checks++; if (rd_i !== 64'hAAAA) $display("FAIL alu_rd_i: got %h want aaaa", rd_i); else passed++;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
    checks++; if (load !== 1'b0) $display("FAIL alu_idle_load: got %b want 0", load); else passed++;
    checks++; if (rd_addr !== 5'd5) $display("FAIL alu_hold_addr: got %0d want 5", rd_addr); else passed++;
  endtask

  task automatic test_mdu_only();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'h1234);
    checks++; if (mdu_ready !== 1'b1) $display("FAIL mdu_ready_empty: got %b want 1", mdu_ready); else passed++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    checks++; if (pending_o !== 32'h80) $display("FAIL mdu_pending7: got %h want 00000080", pending_o); else passed++;
    checks++; if (load !== 1'b0) $display("FAIL mdu_early_load: got %b want 0", load); else passed++;
    tick();
    checks++; if (load !== 1'b1 || rd_addr !== 5'd7 || rd_i !== 64'h1234)
      $display("FAIL mdu_write: got load=%b addr=%0d data=%h want 1/7/1234", load, rd_addr, rd_i);
    else passed++;
    checks++; if (pending_o !== 32'd0) $display("FAIL mdu_pending_clear: got %h want 0", pending_o); else passed++;
  endtask

  task automatic test_contention();
    drive(1'b1, 5'd1, 64'hA1, 1'b1, 5'd3, 64'hD3);
    tick();
    drive(1'b1, 5'd2, 64'hA2, 1'b1, 5'd9, 64'hD9);
    tick();
    drive(1'b1, 5'd2, 64'hA2, 1'b1, 5'd11, 64'hDB);
    checks++; if (mdu_ready !== 1'b0) $display("FAIL full_mdu_ready: got %b want 0", mdu_ready); else passed++;
    checks++; if (pending_o !== 32'h208) $display("FAIL full_pending: got %h want 00000208", pending_o); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (stall_o !== 1'b0) $display("FAIL early_stall_%0d: got %b want 0", k, stall_o); else passed++;
      tick();
    end
    checks++; if (stall_o !== 1'b1) $display("FAIL stall_at_maxwait: got %b want 1", stall_o); else passed++;
    tick();
    checks++; if (load !== 1'b1 || rd_addr !== 5'd3 || rd_i !== 64'hD3)
      $display("FAIL stall_write: got load=%b addr=%0d data=%h want 1/3/d3", load, rd_addr, rd_i);
    else passed++;
    checks++; if (stall_o !== 1'b0) $display("FAIL stall_clear: got %b want 0", stall_o); else passed++;
    checks++; if (pending_o !== 32'h200) $display("FAIL after_stall_pending: got %h want 00000200", pending_o); else passed++;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
    checks++; if (rd_addr !== 5'd9 || rd_i !== 64'hD9)
      $display("FAIL drain_write: got addr=%0d data=%h want 9/d9", rd_addr, rd_i);
    else passed++;
  endtask

  task automatic test_x0_filter();
    drive(1'b1, 5'd6, 64'h66, 1'b1, 5'd4, 64'hD4);
    tick();
    drive(1'b1, 5'd6, 64'h67, 1'b1, 5'd0, 64'hDEAD);
    checks++; if (mdu_ready !== 1'b1) $display("FAIL x0_mdu_ready: got %b want 1", mdu_ready); else passed++;
    tick();
    checks++; if (pending_o !== 32'h10) $display("FAIL x0_mdu_discard: got %h want 00000010", pending_o); else passed++;
    checks++; if (rd_addr !== 5'd6 || rd_i !== 64'h67)
      $display("FAIL x0_alu_write: got addr=%0d data=%h want 6/67", rd_addr, rd_i);
    else passed++;
    drive(1'b1, 5'd0, 64'hBAD, 1'b0, 5'd0, '0);
    tick();
    checks++; if (load !== 1'b1 || rd_addr !== 5'd4 || rd_i !== 64'hD4)
      $display("FAIL x0_alu_pop: got load=%b addr=%0d data=%h want 1/4/d4", load, rd_addr, rd_i);
    else passed++;
    checks++; if (pending_o !== 32'd0) $display("FAIL x0_pending_clear: got %h want 0", pending_o); else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd12, 64'hC12);
    tick();
    drive(1'b1, 5'd1, 64'h12, 1'b1, 5'd13, 64'hC13);
    tick();
    checks++; if (mdu_ready !== 1'b0) $display("FAIL mid_full_ready: got %b want 0", mdu_ready); else passed++;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (load !== 1'b0 || rd_addr !== 5'd0 || rd_i !== '0)
      $display("FAIL async_reset_port: got load=%b addr=%0d data=%h want 0/0/0", load, rd_addr, rd_i);
    else passed++;
    checks++; if (pending_o !== 32'd0) $display("FAIL async_reset_pending: got %h want 0", pending_o); else passed++;
    checks++; if (mdu_ready !== 1'b0) $display("FAIL async_reset_ready: got %b want 0", mdu_ready); else passed++;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (mdu_ready !== 1'b1) $display("FAIL mid_release_ready: got %b want 1", mdu_ready); else passed++;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (load !== 1'b0) $display("FAIL stale_write_%0d: got %b want 0", k, load); else passed++;
    end
  endtask

  task automatic test_random();
    logic [4:0] aa;
    logic [4:0] ma;
    for (int c = 0; c < 500; c++) begin
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive(1'($urandom_range(0, 3) != 0), aa, {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0), ma, {$urandom, $urandom});
      checks++; if (mdu_ready !== m_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, mdu_ready, m_ready()); else passed++;
      checks++; if (stall_o !== m_stall()) $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_o, m_stall()); else passed++;
      checks++; if (pending_o !== m_pending()) $display("FAIL rnd_pending c%0d: got %h want %h", c, pending_o, m_pending()); else passed++;
      tick();
      checks++; if (load !== m_load || rd_addr !== m_addr || rd_i !== m_data)
        $display("FAIL rnd_write c%0d: got %b/%0d/%h want %b/%0d/%h", c, load, rd_addr, rd_i, m_load, m_addr, m_data);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_mdu_only();
    test_contention();
    test_x0_filter();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
